muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//  Multi-cycle sequencer for MULT/MULTU/DIV/DIVU in the EX stage of the pipeline.
//  Accepts an R-type funct with two operands and runs a WIDTH-iteration shift-add (mul) or restoring
//  shift-subtract (div) loop on an internal add/sub datapath. It holds the HI/LO results and drives
//  busy so the hazard unit can stall the pipeline while a HI/LO op is in flight.
// PARAMETERS
//  WIDTH   32  operand width; HI and LO are each WIDTH bits
//  CNT_W   6   iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk      in   1      rising-edge clock
//  reset    in   1      asynchronous, active-high reset
//  start    in   1      request from EX: sample funct/a/b this cycle
//  funct    in   6      011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU
//  a        in   WIDTH  rs operand (multiplicand / dividend)
//  b        in   WIDTH  rt operand (multiplier / divisor)
//  abort    in   1      pipeline flush; cancels an in-flight op
//  busy     out  1      op in flight; hazard unit stalls MFHI/MFLO/new muldiv while high
//  done     out  1      one-cycle pulse: hi/lo just updated
//  hi       out  WIDTH  HI register (mul: upper product; div: remainder)
//  lo       out  WIDTH  LO register (mul: lower product; div: quotient)
// BEHAVIOUR
//  Reset (async): state=IDLE; busy=0, done=0, hi=0, lo=0; counter and work regs cleared.
//  FSM: IDLE -> RUN -> FIX -> DONE -> IDLE.
//   IDLE: if start && funct is one of the four codes: latch operands (signed ops take magnitudes,
//         record result signs), cnt=0, goto RUN. Start with any other funct is ignored.
//   RUN : one iteration per cycle, cnt++; after WIDTH iterations (cnt==WIDTH-1) goto FIX.
//   FIX : apply sign correction -- signed product negated if sign(a)!=sign(b); quotient negated if
//         signs differ; remainder takes sign of a. Write hi/lo at the end of this cycle; goto DONE.
//   DONE: done=1 for one cycle, busy=0; goto IDLE. start in DONE is ignored (hazard unit re-issues).
//  busy=1 in RUN and FIX. Latency start->done = WIDTH+2 cycles (WIDTH=32: 34).
//  start while busy or in DONE: ignored; hi/lo/operands unaffected.
//  abort in RUN/FIX: goto IDLE next cycle; hi/lo keep prior values; no done pulse. abort in IDLE/DONE:
//   no effect (DONE has already committed hi/lo). abort and start in the same IDLE cycle: abort wins,
//   op not accepted.
//  Arithmetic: mul uses a 2*WIDTH accumulator, full-width result, no overflow. DIVU/DIV by zero:
//   lo=all ones, hi=a (raw, unsigned view). DIV of most-negative by -1: lo=most-negative, hi=0 (wrap).
//  hi/lo change only at end of FIX; they are stable for the whole of busy.
//  Reset asserted mid-op: immediate return to IDLE with all outputs at reset values.
// CONFIGURATION
//  MULDIV_DIV0_TRAP_EN defined: adds output port div0 (1 bit, reset 0). Div by zero is detected in
//   IDLE at accept, skips RUN, goes to FIX with no write, then DONE pulses done=1 and div0=1 together
//   (2 cycles). hi/lo are left unchanged.
//  Not defined: no div0 port; div by zero runs the full loop with the results given above.
// TESTING
//  MULTU a=FFFFFFFF b=FFFFFFFF -> done at cycle 34; hi=FFFFFFFE lo=00000001; busy high cycles 1..33.
//  MULT a=FFFFFFFD(-3) b=00000007 -> hi=FFFFFFFF lo=FFFFFFEB (-21).
//  DIV a=FFFFFFF9(-7) b=00000002 -> lo=FFFFFFFD(-3) hi=FFFFFFFF(-1); DIVU 100/7 -> lo=0000000E hi=00000002.
//  DIVU a=12345678 b=0 -> lo=FFFFFFFF hi=12345678 (macro off); with macro: done+div0 at cycle 2,
//   hi/lo unchanged.
//  Start MULT, abort at cycle 10 -> busy falls at cycle 11, no done, hi/lo keep prior values;
//   start during RUN is ignored.
//  Assert reset at cycle 5 of a DIV -> busy=0, hi=lo=0 immediately; next start is accepted normally.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer holding HI/LO for the EX stage.
// Define MULDIV_DIV0_TRAP_EN to short-circuit divide-by-zero and flag it on div0.

module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
`ifdef MULDIV_DIV0_TRAP_EN
    output logic             div0,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;
    logic             is_div;
    logic             neg_main;
    logic             neg_rem;
    logic             div_zero;
`ifdef MULDIV_DIV0_TRAP_EN
    logic             skip;
`endif

    logic             valid_op;
    logic             op_div;
    logic             op_signed;
    logic             sign_a;
    logic             sign_b;
    logic             accept;
    logic             b_zero;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    assign valid_op  = (funct[5:2] == 4'b0110);
    assign op_div    = funct[1];
    assign op_signed = ~funct[0];
    assign sign_a    = op_signed & a[WIDTH-1];
    assign sign_b    = op_signed & b[WIDTH-1];
    assign mag_a     = sign_a ? -a : a;
    assign mag_b     = sign_b ? -b : b;
    assign b_zero    = (b == '0);
    assign accept    = (state == S_IDLE) & start & valid_op & ~abort;

    // Shared add/sub: mul adds the multiplicand into the upper half, div trial-subtracts
    // the divisor from the remainder shifted left by one dividend bit.
    logic [WIDTH:0]   op_x;
    logic [WIDTH:0]   op_y;
    logic [WIDTH+1:0] op_y_ext;
    logic [WIDTH+1:0] sum;

    always_comb begin
        op_x = '0;
        op_y = '0;
        if (is_div) begin
            op_x = {acc_hi, acc_lo[WIDTH-1]};
            op_y = {1'b0, opnd};
        end else begin
            op_x = {1'b0, acc_hi};
            op_y = acc_lo[0] ? {1'b0, opnd} : '0;
        end
        op_y_ext = is_div ? ~{1'b0, op_y} : {1'b0, op_y};
        sum      = {1'b0, op_x} + op_y_ext + {{(WIDTH+1){1'b0}}, is_div};
    end

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   hi_fix;
    logic [WIDTH-1:0]   lo_fix;

    // A zero divisor leaves the dividend magnitude in acc_hi, so the remainder sign fix restores raw a.
    assign prod     = {acc_hi, acc_lo};
    assign prod_fix = neg_main ? -prod : prod;
    assign quo_fix  = div_zero ? '1 : (neg_main ? -acc_lo : acc_lo);
    assign rem_fix  = neg_rem ? -acc_hi : acc_hi;
    assign hi_fix   = is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    assign lo_fix   = is_div ? quo_fix : prod_fix[WIDTH-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
`ifdef MULDIV_DIV0_TRAP_EN
            skip     <= 1'b0;
            div0     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cnt      <= '0;
                        is_div   <= op_div;
                        acc_hi   <= '0;
                        acc_lo   <= op_div ? mag_a : mag_b;
                        opnd     <= op_div ? mag_b : mag_a;
                        neg_main <= sign_a ^ sign_b;
                        neg_rem  <= sign_a;
                        div_zero <= op_div & b_zero;
`ifdef MULDIV_DIV0_TRAP_EN
                        skip     <= op_div & b_zero;
                        state    <= (op_div && b_zero) ? S_FIX : S_RUN;
`else
                        state    <= S_RUN;
`endif
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else begin
                        if (is_div) begin
                            if (sum[WIDTH+1]) begin
                                acc_hi <= op_x[WIDTH-1:0];
                                acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                            end else begin
                                acc_hi <= sum[WIDTH-1:0];
                                acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                            end
                        end else begin
                            acc_hi <= sum[WIDTH:1];
                            acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
                        end
                        if (cnt == CNT_W'(WIDTH-1)) begin
                            state <= S_FIX;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                S_FIX: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else begin
`ifdef MULDIV_DIV0_TRAP_EN
                        if (!skip) begin
                            hi <= hi_fix;
                            lo <= lo_fix;
                        end
                        div0 <= skip;
`else
                        hi <= hi_fix;
                        lo <= lo_fix;
`endif
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
`ifdef MULDIV_DIV0_TRAP_EN
                    div0 <= 1'b0;
`endif
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_RUN) | (state == S_FIX);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed and random ops against a plain-arithmetic HI/LO model.
// Build with MULDIV_DIV0_TRAP_EN defined to exercise the div0 short-circuit.

module tb_muldiv_sequencer;

    localparam int W = 32;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [5:0]   funct;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         abort;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
`ifdef MULDIV_DIV0_TRAP_EN
    logic         div0;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;

    // Bench's own view of what HI/LO should currently hold.
    logic [W-1:0] mdl_hi;
    logic [W-1:0] mdl_lo;

    always #5 clk = ~clk;

    muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .funct (funct),
        .a     (a),
        .b     (b),
        .abort (abort),
`ifdef MULDIV_DIV0_TRAP_EN
        .div0  (div0),
`endif
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    // Result as {HI, LO} computed with wide integer arithmetic.
    function automatic logic [63:0] ref_model(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
        longint          sx;
        longint          sy;
        longint          sq;
        longint          sr;
        longint unsigned ux;
        longint unsigned uy;
        longint unsigned uq;
        longint unsigned ur;
        logic [63:0]     res;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ux  = {32'd0, x};
        uy  = {32'd0, y};
        res = '0;
        case (f)
            F_MULT:  res = sx * sy;
            F_MULTU: res = ux * uy;
            F_DIV: begin
                if (y == 0) begin
                    res = {x, 32'hFFFF_FFFF};
                end else begin
                    sq  = sx / sy;
                    sr  = sx % sy;
                    res = {sr[31:0], sq[31:0]};
                end
            end
            F_DIVU: begin
                if (y == 0) begin
                    res = {x, 32'hFFFF_FFFF};
                end else begin
                    uq  = ux / uy;
                    ur  = ux % uy;
                    res = {ur[31:0], uq[31:0]};
                end
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Called at a falling edge; returns one cycle later with start dropped and operands scrambled.
    task automatic applyStimulus(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
        funct = f;
        a     = x;
        b     = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        funct = 6'($urandom);
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic runOp(input string tag, input logic [5:0] f, input logic [W-1:0] x,
                         input logic [W-1:0] y, input bit noisy);
        int          cyc;
        int          busy_cyc;
        bit          stable;
        bit          trap;
        logic [63:0] r;
        trap = 1'b0;
`ifdef MULDIV_DIV0_TRAP_EN
        trap = (f[1] == 1'b1) && (y == '0);
`endif
        applyStimulus(f, x, y);
        cyc      = 1;
        busy_cyc = 0;
        stable   = 1'b1;
        while (done !== 1'b1 && cyc < 100) begin
            if (busy === 1'b1) busy_cyc++;
            if (hi !== mdl_hi || lo !== mdl_lo) stable = 1'b0;
            if (noisy) begin
                start = 1'($urandom);
                funct = {4'b0110, 2'($urandom)};
                a     = $urandom;
                b     = $urandom;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        checkOutput({tag, " latency"}, 64'(cyc), trap ? 64'd2 : 64'd34);
        checkOutput({tag, " busy cycles"}, 64'(busy_cyc), trap ? 64'd1 : 64'd33);
        checkOutput({tag, " hi/lo stable while busy"}, 64'(stable), 64'd1);
        checkOutput({tag, " busy at done"}, 64'(busy), 64'd0);
        if (!trap) begin
            r      = ref_model(f, x, y);
            mdl_hi = r[63:32];
            mdl_lo = r[31:0];
        end
        checkOutput({tag, " hi"}, 64'(hi), 64'(mdl_hi));
        checkOutput({tag, " lo"}, 64'(lo), 64'(mdl_lo));
`ifdef MULDIV_DIV0_TRAP_EN
        checkOutput({tag, " div0"}, 64'(div0), 64'(trap));
`endif
        // A request arriving in the done cycle must be dropped.
        start = 1'b1;
        funct = F_MULTU;
        a     = $urandom;
        b     = $urandom;
        @(negedge clk);
        start = 1'b0;
        checkOutput({tag, " done one cycle"}, 64'(done), 64'd0);
        checkOutput({tag, " start in done ignored"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int           seen;
        logic [5:0]   fr;
        logic [W-1:0] xr;
        logic [W-1:0] yr;
        logic [5:0]   codes [4];

        codes[0] = F_MULT;
        codes[1] = F_MULTU;
        codes[2] = F_DIV;
        codes[3] = F_DIVU;
        reset  = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        funct  = '0;
        a      = '0;
        b      = '0;
        mdl_hi = '0;
        mdl_lo = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset hi", 64'(hi), 64'd0);
        checkOutput("reset lo", 64'(lo), 64'd0);
`ifdef MULDIV_DIV0_TRAP_EN
        checkOutput("reset div0", 64'(div0), 64'd0);
`endif
        reset = 1'b0;
        @(negedge clk);

        runOp("multu max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        runOp("mult -3*7", F_MULT, 32'hFFFF_FFFD, 32'h0000_0007, 1'b1);
        runOp("div -7/2", F_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
        runOp("divu 100/7", F_DIVU, 32'd100, 32'd7, 1'b1);
        runOp("divu by zero", F_DIVU, 32'h1234_5678, 32'h0, 1'b0);
        runOp("div neg by zero", F_DIV, 32'h8000_0005, 32'h0, 1'b0);
        runOp("div minneg/-1", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        runOp("mult minneg^2", F_MULT, 32'h8000_0000, 32'h8000_0000, 1'b1);

        // Abort in the middle of the loop: no done, HI/LO untouched.
        applyStimulus(F_MULT, $urandom, $urandom);
        repeat (9) @(negedge clk);
        checkOutput("abort run busy before", 64'(busy), 64'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort run busy after", 64'(busy), 64'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1;
        end
        checkOutput("abort run no done", 64'(seen), 64'd0);
        checkOutput("abort run hi", 64'(hi), 64'(mdl_hi));
        checkOutput("abort run lo", 64'(lo), 64'(mdl_lo));

        // Abort in the final fixup cycle must still suppress the write.
        applyStimulus(F_MULTU, 32'hDEAD_BEEF, 32'h1234_5678);
        repeat (32) @(negedge clk);
        checkOutput("abort fix busy before", 64'(busy), 64'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort fix busy after", 64'(busy), 64'd0);
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1;
        end
        checkOutput("abort fix no done", 64'(seen), 64'd0);
        checkOutput("abort fix hi", 64'(hi), 64'(mdl_hi));
        checkOutput("abort fix lo", 64'(lo), 64'(mdl_lo));

        abort = 1'b1;
        applyStimulus(F_DIVU, 32'd50, 32'd3);
        abort = 1'b0;
        checkOutput("abort beats start", 64'(busy), 64'd0);

        applyStimulus(6'b011100, 32'd5, 32'd6);
        checkOutput("bad funct ignored", 64'(busy), 64'd0);
        @(negedge clk);

        // Asynchronous reset five cycles into a divide.
        applyStimulus(F_DIV, 32'h7FFF_0000, 32'h0000_0123);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        mdl_hi = '0;
        mdl_lo = '0;
        checkOutput("midop reset busy", 64'(busy), 64'd0);
        checkOutput("midop reset done", 64'(done), 64'd0);
        checkOutput("midop reset hi", 64'(hi), 64'd0);
        checkOutput("midop reset lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        runOp("after reset div", F_DIV, 32'h7FFF_0000, 32'h0000_0123, 1'b0);

        for (int i = 0; i < 16; i++) begin
            fr = codes[$urandom_range(0, 3)];
            xr = $urandom;
            yr = $urandom;
            case ($urandom_range(0, 5))
                0: yr = '0;
                1: xr = 32'h8000_0000;
                2: yr = 32'hFFFF_FFFF;
                3: yr = 32'($urandom_range(1, 255));
                default: ;
            endcase
            runOp("random", fr, xr, yr, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
